// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers issued instructions, captures operands
// from the ALU/LSB CDBs and dispatches one ready entry per cycle. ALU_RS_AGE_ORDER_EN enables oldest-first select.
module alu_rs #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback_config,
    input  logic             in_config,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_precise,
    input  logic [31:0]      in_PC,
    input  logic [31:0]      in_imm,
    input  logic [TAG_W-1:0] in_rob_entry,
    input  logic             in_rs1_ready,
    input  logic             in_rs2_ready,
    input  logic [31:0]      in_rs1_val,
    input  logic [31:0]      in_rs2_val,
    input  logic [TAG_W-1:0] in_rs1_tag,
    input  logic [TAG_W-1:0] in_rs2_tag,
    input  logic             in_alu_cdb_config,
    input  logic [TAG_W-1:0] in_alu_cdb_entry,
    input  logic [31:0]      in_alu_cdb_val,
    input  logic             in_lsb_cdb_config,
    input  logic [TAG_W-1:0] in_lsb_cdb_entry,
    input  logic [31:0]      in_lsb_cdb_val,
    output logic             out_full,
    output logic             out_config,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [31:0]      out_PC,
    output logic [31:0]      out_imm,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_precise,
    output logic [TAG_W-1:0] out_rob_entry
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [6:0]       opcode_q  [DEPTH];
    logic [6:0]       opcode_d  [DEPTH];
    logic [2:0]       precise_q [DEPTH];
    logic [2:0]       precise_d [DEPTH];
    logic [31:0]      pc_q      [DEPTH];
    logic [31:0]      pc_d      [DEPTH];
    logic [31:0]      imm_q     [DEPTH];
    logic [31:0]      imm_d     [DEPTH];
    logic [TAG_W-1:0] rob_q     [DEPTH];
    logic [TAG_W-1:0] rob_d     [DEPTH];
    logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
    logic [31:0]      rs1_val_q [DEPTH];
    logic [31:0]      rs1_val_d [DEPTH];
    logic [31:0]      rs2_val_q [DEPTH];
    logic [31:0]      rs2_val_d [DEPTH];
    logic [TAG_W-1:0] rs1_tag_q [DEPTH];
    logic [TAG_W-1:0] rs1_tag_d [DEPTH];
    logic [TAG_W-1:0] rs2_tag_q [DEPTH];
    logic [TAG_W-1:0] rs2_tag_d [DEPTH];
`ifdef ALU_RS_AGE_ORDER_EN
    logic [IW-1:0]    age_q     [DEPTH];
    logic [IW-1:0]    age_d     [DEPTH];
    logic [IW:0]      count;
    logic [IW-1:0]    best_age;
`endif

    logic             out_config_q, out_config_d;
    logic [31:0]      out_a_q, out_a_d, out_b_q, out_b_d;
    logic [31:0]      out_pc_q, out_pc_d, out_imm_q, out_imm_d;
    logic [6:0]       out_opcode_q, out_opcode_d;
    logic [2:0]       out_precise_q, out_precise_d;
    logic [TAG_W-1:0] out_rob_q, out_rob_d;

    logic [DEPTH-1:0] ready_vec;
    logic             sel_valid, free_valid;
    logic [IW-1:0]    sel_idx, free_idx;
    logic [32:0]      in_rs1_res, in_rs2_res;

    // Returns {ready, value}: a waiting operand resolves from whichever CDB matches, ALU first.
    function automatic logic [32:0] resolve(
        input logic             r,
        input logic [31:0]      v,
        input logic [TAG_W-1:0] t,
        input logic             ah,
        input logic [TAG_W-1:0] at,
        input logic [31:0]      av,
        input logic             lh,
        input logic [TAG_W-1:0] lt,
        input logic [31:0]      lv
    );
        logic [32:0] res;
        res = {r, v};
        if (!r) begin
            if (ah && at == t) begin
                res = {1'b1, av};
            end else if (lh && lt == t) begin
                res = {1'b1, lv};
            end
        end
        return res;
    endfunction

    assign out_full  = &busy_q;
    assign ready_vec = busy_q & rs1_rdy_q & rs2_rdy_q;

    always_comb begin
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_valid = 1'b1;
                free_idx   = i[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
`ifdef ALU_RS_AGE_ORDER_EN
        best_age  = '0;
        count     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + {{IW{1'b0}}, busy_q[i]};
            if (ready_vec[i] && (!sel_valid || age_q[i] < best_age)) begin
                sel_valid = 1'b1;
                sel_idx   = i[IW-1:0];
                best_age  = age_q[i];
            end
        end
`else
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_valid = 1'b1;
                sel_idx   = i[IW-1:0];
            end
        end
`endif
    end

    assign in_rs1_res = resolve(in_rs1_ready, in_rs1_val, in_rs1_tag,
                                in_alu_cdb_config, in_alu_cdb_entry, in_alu_cdb_val,
                                in_lsb_cdb_config, in_lsb_cdb_entry, in_lsb_cdb_val);
    assign in_rs2_res = resolve(in_rs2_ready, in_rs2_val, in_rs2_tag,
                                in_alu_cdb_config, in_alu_cdb_entry, in_alu_cdb_val,
                                in_lsb_cdb_config, in_lsb_cdb_entry, in_lsb_cdb_val);

    always_comb begin
        busy_d        = busy_q;
        opcode_d      = opcode_q;
        precise_d     = precise_q;
        pc_d          = pc_q;
        imm_d         = imm_q;
        rob_d         = rob_q;
        rs1_rdy_d     = rs1_rdy_q;
        rs2_rdy_d     = rs2_rdy_q;
        rs1_val_d     = rs1_val_q;
        rs2_val_d     = rs2_val_q;
        rs1_tag_d     = rs1_tag_q;
        rs2_tag_d     = rs2_tag_q;
`ifdef ALU_RS_AGE_ORDER_EN
        age_d         = age_q;
`endif
        out_config_d  = out_config_q;
        out_a_d       = out_a_q;
        out_b_d       = out_b_q;
        out_pc_d      = out_pc_q;
        out_imm_d     = out_imm_q;
        out_opcode_d  = out_opcode_q;
        out_precise_d = out_precise_q;
        out_rob_d     = out_rob_q;

        if (rdy) begin
            if (rollback_config) begin
                busy_d       = '0;
                out_config_d = 1'b0;
`ifdef ALU_RS_AGE_ORDER_EN
                for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
`endif
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_q[i]) begin
                        {rs1_rdy_d[i], rs1_val_d[i]} = resolve(rs1_rdy_q[i], rs1_val_q[i], rs1_tag_q[i],
                            in_alu_cdb_config, in_alu_cdb_entry, in_alu_cdb_val,
                            in_lsb_cdb_config, in_lsb_cdb_entry, in_lsb_cdb_val);
                        {rs2_rdy_d[i], rs2_val_d[i]} = resolve(rs2_rdy_q[i], rs2_val_q[i], rs2_tag_q[i],
                            in_alu_cdb_config, in_alu_cdb_entry, in_alu_cdb_val,
                            in_lsb_cdb_config, in_lsb_cdb_entry, in_lsb_cdb_val);
                    end
                end

                out_config_d = sel_valid;
                if (sel_valid) begin
                    busy_d[sel_idx] = 1'b0;
                    out_a_d         = rs1_val_q[sel_idx];
                    out_b_d         = rs2_val_q[sel_idx];
                    out_pc_d        = pc_q[sel_idx];
                    out_imm_d       = imm_q[sel_idx];
                    out_opcode_d    = opcode_q[sel_idx];
                    out_precise_d   = precise_q[sel_idx];
                    out_rob_d       = rob_q[sel_idx];
                end

                // Free slot comes from registered busy, so a same-cycle dispatch never frees it early.
                if (in_config && free_valid) begin
                    busy_d[free_idx]    = 1'b1;
                    opcode_d[free_idx]  = in_opcode;
                    precise_d[free_idx] = in_precise;
                    pc_d[free_idx]      = in_PC;
                    imm_d[free_idx]     = in_imm;
                    rob_d[free_idx]     = in_rob_entry;
                    {rs1_rdy_d[free_idx], rs1_val_d[free_idx]} = in_rs1_res;
                    {rs2_rdy_d[free_idx], rs2_val_d[free_idx]} = in_rs2_res;
                    rs1_tag_d[free_idx] = in_rs1_tag;
                    rs2_tag_d[free_idx] = in_rs2_tag;
`ifdef ALU_RS_AGE_ORDER_EN
                    age_d[free_idx]     = count[IW-1:0];
`endif
                end

`ifdef ALU_RS_AGE_ORDER_EN
                if (sel_valid) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (busy_d[i] && age_d[i] > age_q[sel_idx]) age_d[i] = age_d[i] - 1'b1;
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q        <= '0;
            rs1_rdy_q     <= '0;
            rs2_rdy_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opcode_q[i]  <= '0;
                precise_q[i] <= '0;
                pc_q[i]      <= '0;
                imm_q[i]     <= '0;
                rob_q[i]     <= '0;
                rs1_val_q[i] <= '0;
                rs2_val_q[i] <= '0;
                rs1_tag_q[i] <= '0;
                rs2_tag_q[i] <= '0;
`ifdef ALU_RS_AGE_ORDER_EN
                age_q[i]     <= '0;
`endif
            end
            out_config_q  <= 1'b0;
            out_a_q       <= '0;
            out_b_q       <= '0;
            out_pc_q      <= '0;
            out_imm_q     <= '0;
            out_opcode_q  <= '0;
            out_precise_q <= '0;
            out_rob_q     <= '0;
        end else begin
            busy_q        <= busy_d;
            rs1_rdy_q     <= rs1_rdy_d;
            rs2_rdy_q     <= rs2_rdy_d;
            opcode_q      <= opcode_d;
            precise_q     <= precise_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            rob_q         <= rob_d;
            rs1_val_q     <= rs1_val_d;
            rs2_val_q     <= rs2_val_d;
            rs1_tag_q     <= rs1_tag_d;
            rs2_tag_q     <= rs2_tag_d;
`ifdef ALU_RS_AGE_ORDER_EN
            age_q         <= age_d;
`endif
            out_config_q  <= out_config_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_pc_q      <= out_pc_d;
            out_imm_q     <= out_imm_d;
            out_opcode_q  <= out_opcode_d;
            out_precise_q <= out_precise_d;
            out_rob_q     <= out_rob_d;
        end
    end

    assign out_config    = out_config_q;
    assign out_a         = out_a_q;
    assign out_b         = out_b_q;
    assign out_PC        = out_pc_q;
    assign out_imm       = out_imm_q;
    assign out_opcode    = out_opcode_q;
    assign out_precise   = out_precise_q;
    assign out_rob_entry = out_rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: dispatch latency, CDB wake-up/forwarding, full, rollback, rdy stall,
// select order (follows ALU_RS_AGE_ORDER_EN) and asynchronous reset.
module tb_alu_rs;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst, rdy, rollback_config, in_config;
    logic [6:0]       in_opcode;
    logic [2:0]       in_precise;
    logic [31:0]      in_PC, in_imm;
    logic [TAG_W-1:0] in_rob_entry;
    logic             in_rs1_ready, in_rs2_ready;
    logic [31:0]      in_rs1_val, in_rs2_val;
    logic [TAG_W-1:0] in_rs1_tag, in_rs2_tag;
    logic             in_alu_cdb_config, in_lsb_cdb_config;
    logic [TAG_W-1:0] in_alu_cdb_entry, in_lsb_cdb_entry;
    logic [31:0]      in_alu_cdb_val, in_lsb_cdb_val;
    logic             out_full, out_config;
    logic [31:0]      out_a, out_b, out_PC, out_imm;
    logic [6:0]       out_opcode;
    logic [2:0]       out_precise;
    logic [TAG_W-1:0] out_rob_entry;

    int n_checks = 0;
    int n_errors = 0;

    alu_rs #(.DEPTH(8), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_config(rollback_config),
        .in_config(in_config), .in_opcode(in_opcode), .in_precise(in_precise),
        .in_PC(in_PC), .in_imm(in_imm), .in_rob_entry(in_rob_entry),
        .in_rs1_ready(in_rs1_ready), .in_rs2_ready(in_rs2_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
        .in_alu_cdb_config(in_alu_cdb_config), .in_alu_cdb_entry(in_alu_cdb_entry),
        .in_alu_cdb_val(in_alu_cdb_val),
        .in_lsb_cdb_config(in_lsb_cdb_config), .in_lsb_cdb_entry(in_lsb_cdb_entry),
        .in_lsb_cdb_val(in_lsb_cdb_val),
        .out_full(out_full), .out_config(out_config), .out_a(out_a), .out_b(out_b),
        .out_PC(out_PC), .out_imm(out_imm), .out_opcode(out_opcode),
        .out_precise(out_precise), .out_rob_entry(out_rob_entry)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic alu_cdb(input logic [TAG_W-1:0] e, input logic [31:0] v);
        in_alu_cdb_config = 1'b1;
        in_alu_cdb_entry  = e;
        in_alu_cdb_val    = v;
    endtask

    task automatic lsb_cdb(input logic [TAG_W-1:0] e, input logic [31:0] v);
        in_lsb_cdb_config = 1'b1;
        in_lsb_cdb_entry  = e;
        in_lsb_cdb_val    = v;
    endtask

    task automatic idle();
        in_config         = 1'b0;
        rollback_config   = 1'b0;
        in_alu_cdb_config = 1'b0;
        in_lsb_cdb_config = 1'b0;
    endtask

    task automatic set_issue(input logic [TAG_W-1:0] rob,
                             input logic r1, input logic [31:0] v1, input logic [TAG_W-1:0] t1,
                             input logic r2, input logic [31:0] v2, input logic [TAG_W-1:0] t2);
        in_config    = 1'b1;
        in_opcode    = 7'b0110011;
        in_precise   = 3'b000;
        in_PC        = 32'h1000 + {28'd0, rob};
        in_imm       = 32'd0;
        in_rob_entry = rob;
        in_rs1_ready = r1;
        in_rs1_val   = v1;
        in_rs1_tag   = t1;
        in_rs2_ready = r2;
        in_rs2_val   = v2;
        in_rs2_tag   = t2;
    endtask

    // Issue held for exactly one edge; any CDB driven beforehand is dropped after that edge.
    task automatic issue(input logic [TAG_W-1:0] rob,
                         input logic r1, input logic [31:0] v1, input logic [TAG_W-1:0] t1,
                         input logic r2, input logic [31:0] v2, input logic [TAG_W-1:0] t2);
        set_issue(rob, r1, v1, t1, r2, v2, t2);
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        idle();
        set_issue('0, 1'b0, '0, '0, 1'b0, '0, '0);
        in_config = 1'b0;
        tick();
        tick();
        check("rst_config", {31'd0, out_config}, 32'd0);
        check("rst_full", {31'd0, out_full}, 32'd0);
        check("rst_a", out_a, 32'd0);
        check("rst_rob", {28'd0, out_rob_entry}, 32'd0);
        rst = 1'b1;
        tick();

        // basic ADDI dispatch
        set_issue(4'd3, 1'b1, 32'd5, '0, 1'b1, 32'd0, '0);
        in_opcode = 7'b0010011;
        in_imm    = 32'd7;
        in_PC     = 32'h0000_0100;
        tick();
        idle();
        check("basic_wait", {31'd0, out_config}, 32'd0);
        tick();
        check("basic_config", {31'd0, out_config}, 32'd1);
        check("basic_a", out_a, 32'd5);
        check("basic_imm", out_imm, 32'd7);
        check("basic_rob", {28'd0, out_rob_entry}, 32'd3);
        check("basic_opcode", {25'd0, out_opcode}, 32'h13);
        check("basic_pc", out_PC, 32'h100);
        tick();
        check("basic_pulse", {31'd0, out_config}, 32'd0);

        // CDB wake-up
        issue(4'd2, 1'b0, '0, 4'd1, 1'b1, 32'd10, '0);
        check("wake_none0", {31'd0, out_config}, 32'd0);
        tick();
        check("wake_none1", {31'd0, out_config}, 32'd0);
        alu_cdb(4'd1, 32'h20);
        tick();
        idle();
        check("wake_capture", {31'd0, out_config}, 32'd0);
        tick();
        check("wake_config", {31'd0, out_config}, 32'd1);
        check("wake_a", out_a, 32'h20);
        check("wake_b", out_b, 32'd10);
        check("wake_rob", {28'd0, out_rob_entry}, 32'd2);
        tick();
        check("wake_pulse", {31'd0, out_config}, 32'd0);

        // same-cycle forwarding from LSB bus
        lsb_cdb(4'd6, 32'hFFFF_FFFF);
        issue(4'd5, 1'b1, 32'd1, '0, 1'b0, '0, 4'd6);
        check("fwd_wait", {31'd0, out_config}, 32'd0);
        tick();
        check("fwd_config", {31'd0, out_config}, 32'd1);
        check("fwd_b", out_b, 32'hFFFF_FFFF);
        check("fwd_rob", {28'd0, out_rob_entry}, 32'd5);

        // both buses match the same tag: ALU wins
        alu_cdb(4'd4, 32'h11);
        lsb_cdb(4'd4, 32'h22);
        issue(4'd9, 1'b0, '0, 4'd4, 1'b1, 32'd0, '0);
        tick();
        check("prio_config", {31'd0, out_config}, 32'd1);
        check("prio_a", out_a, 32'h11);
        tick();
        check("prio_pulse", {31'd0, out_config}, 32'd0);

        // fill to DEPTH, drop the extra issue, then drain in index order
        for (int k = 0; k < 8; k++) begin
            issue(k[TAG_W-1:0], 1'b0, '0, 4'd9, 1'b1, k, '0);
        end
        check("full_set", {31'd0, out_full}, 32'd1);
        check("full_nodisp", {31'd0, out_config}, 32'd0);
        issue(4'd15, 1'b1, 32'hDEAD, '0, 1'b1, 32'hBEEF, '0);
        check("full_drop", {31'd0, out_full}, 32'd1);
        alu_cdb(4'd9, 32'h99);
        tick();
        idle();
        check("full_capture", {31'd0, out_config}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("drain_config", {31'd0, out_config}, 32'd1);
            check("drain_rob", {28'd0, out_rob_entry}, k);
            check("drain_b", out_b, k);
            if (k == 0) begin
                check("drain_a", out_a, 32'h99);
                check("drain_full", {31'd0, out_full}, 32'd0);
            end
        end
        tick();
        check("drain_end", {31'd0, out_config}, 32'd0);

        // rollback beats a simultaneous wake-up and issue
        for (int k = 0; k < 4; k++) begin
            issue(k[TAG_W-1:0], 1'b0, '0, 4'd3, 1'b1, 32'd0, '0);
        end
        set_issue(4'd8, 1'b1, 32'h88, '0, 1'b1, 32'd0, '0);
        alu_cdb(4'd3, 32'h33);
        rollback_config = 1'b1;
        tick();
        idle();
        check("rb_full", {31'd0, out_full}, 32'd0);
        check("rb_config", {31'd0, out_config}, 32'd0);
        tick();
        check("rb_nodisp", {31'd0, out_config}, 32'd0);
        alu_cdb(4'd3, 32'h33);
        tick();
        idle();
        tick();
        check("rb_empty", {31'd0, out_config}, 32'd0);
        issue(4'd7, 1'b1, 32'h77, '0, 1'b1, 32'd0, '0);
        tick();
        check("rb_reissue", {31'd0, out_config}, 32'd1);
        check("rb_reissue_a", out_a, 32'h77);
        tick();

        // rdy low freezes state and outputs
        issue(4'd6, 1'b1, 32'h66, '0, 1'b1, 32'd0, '0);
        rdy = 1'b0;
        tick();
        check("stall_hold0", {31'd0, out_config}, 32'd0);
        tick();
        check("stall_hold0b", {31'd0, out_config}, 32'd0);
        rdy = 1'b1;
        tick();
        check("stall_disp", {31'd0, out_config}, 32'd1);
        check("stall_a", out_a, 32'h66);
        rdy = 1'b0;
        tick();
        check("stall_hold1", {31'd0, out_config}, 32'd1);
        rdy = 1'b1;
        tick();
        check("stall_release", {31'd0, out_config}, 32'd0);

        // select order: B(entry0) ready, A(entry1) waits on tag 1, C reuses entry0
        issue(4'd11, 1'b1, 32'hB, '0, 1'b1, 32'd0, '0);
        check("age_b_wait", {31'd0, out_config}, 32'd0);
        issue(4'd10, 1'b0, '0, 4'd1, 1'b1, 32'd0, '0);
        check("age_b_disp", {28'd0, out_rob_entry}, 32'd11);
        alu_cdb(4'd1, 32'hA);
        issue(4'd12, 1'b1, 32'hC, '0, 1'b1, 32'd0, '0);
        check("age_gap", {31'd0, out_config}, 32'd0);
        tick();
        check("age_first_cfg", {31'd0, out_config}, 32'd1);
`ifdef ALU_RS_AGE_ORDER_EN
        check("age_first", {28'd0, out_rob_entry}, 32'd10);
        tick();
        check("age_second", {28'd0, out_rob_entry}, 32'd12);
`else
        check("idx_first", {28'd0, out_rob_entry}, 32'd12);
        tick();
        check("idx_second", {28'd0, out_rob_entry}, 32'd10);
`endif
        check("age_second_cfg", {31'd0, out_config}, 32'd1);
        tick();
        check("age_end", {31'd0, out_config}, 32'd0);

        // asynchronous reset mid-operation
        issue(4'd4, 1'b1, 32'h44, '0, 1'b1, 32'd0, '0);
        issue(4'd5, 1'b0, '0, 4'd2, 1'b1, 32'd0, '0);
        check("arst_pre", {31'd0, out_config}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_config", {31'd0, out_config}, 32'd0);
        check("arst_a", out_a, 32'd0);
        rst = 1'b1;
        alu_cdb(4'd2, 32'h55);
        tick();
        idle();
        tick();
        check("arst_empty", {31'd0, out_config}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
